// File: rtl/simplediv_if.sv
// simplediv_if: start/busy/done handshake and operand/result bus for simplediv
interface simplediv_if;
  logic        start;
  logic        poly;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [63:0] rd;
  logic        busy;
  logic        done;
  modport master (output start, poly, rs1, rs2, input rd, busy, done);
  modport slave  (input start, poly, rs1, rs2, output rd, busy, done);
endinterface

// File: rtl/simplediv.sv
// simplediv: iterative 32-bit unsigned divider, one quotient bit per cycle
// Define CLDIV_EN to add carry-less (GF(2)) polynomial division selected by poly.
module simplediv (
  input logic        clock,
  input logic        reset,
  simplediv_if.slave bus
);
  logic [31:0] q, d, r, r_nxt;
  logic [5:0]  cnt;
  logic        done, q_bit, int_ge;
  logic [32:0] s;
  assign s      = {r, q[31]};
  assign int_ge = s >= {1'b0, d};
`ifdef CLDIV_EN
  logic        m, cl_ge;
  logic [31:0] t;
  assign t     = s[31:0] ^ d;
  // t < s exactly when s holds the leading set bit of d
  assign cl_ge = t < s[31:0];
  always_comb begin
    q_bit = m ? cl_ge : int_ge;
    r_nxt = m ? (cl_ge ? t : s[31:0]) : (int_ge ? s[31:0] - d : s[31:0]);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) m <= 1'b0;
    else if (bus.start) m <= bus.poly;
`else
  always_comb begin
    q_bit = int_ge;
    r_nxt = int_ge ? s[31:0] - d : s[31:0];
  end
`endif
  // the remainder never exceeds 32 bits, so only its low word is stored
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      q    <= '0;
      r    <= '0;
      d    <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (bus.start) begin
      q    <= bus.rs1;
      r    <= '0;
      d    <= bus.rs2;
      cnt  <= 6'd32;
      done <= 1'b0;
    end else if (cnt != 6'd0) begin
      q    <= {q[30:0], q_bit};
      r    <= r_nxt;
      cnt  <= cnt - 6'd1;
      done <= cnt == 6'd1;
    end else begin
      done <= 1'b0;
    end
  assign bus.rd   = {r, q};
  assign bus.busy = cnt != 6'd0;
  assign bus.done = done;
endmodule

// File: tb/tb_simplediv.sv
// tb_simplediv: vector table plus scoreboard-checked corner sequences for simplediv
module tb_simplediv;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  simplediv_if bus ();
  simplediv dut (.clock(clock), .reset(reset), .bus(bus));
  typedef struct {
    logic        poly;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;
  vec_t        v[8];
  logic [63:0] sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] int_model(logic [31:0] a, logic [31:0] b);
    return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
  endfunction
`ifdef CLDIV_EN
  function automatic logic [63:0] cl_model(logic [31:0] a, logic [31:0] b);
    logic [31:0] qq, rr;
    int db;
    qq = '0;
    rr = a;
    if (b == 0) return {a, 32'h0};
    db = 31;
    while (!b[db]) db--;
    for (int i = 31; i >= db; i--)
      if (rr[i]) begin
        rr = rr ^ (b << (i - db));
        qq[i - db] = 1'b1;
      end
    return {rr, qq};
  endfunction
`endif
  function automatic logic [63:0] model(logic p, logic [31:0] a, logic [31:0] b);
`ifdef CLDIV_EN
    return p ? cl_model(a, b) : int_model(a, b);
`else
    return int_model(a, b);
`endif
  endfunction
  always @(negedge clock)
    if (!reset && bus.done) begin
      done_cnt++;
      if (sb.size() == 0) check("spurious_done", 64'd1, 64'd0);
      else check("rd", bus.rd, sb.pop_front());
    end
  task automatic launch(logic p, logic [31:0] a, logic [31:0] b, logic [63:0] e, bit push);
    bus.start = 1'b1;
    bus.poly  = p;
    bus.rs1   = a;
    bus.rs2   = b;
    if (push) sb.push_back(e);
    @(negedge clock);
    bus.start = 1'b0;
    bus.poly  = 1'($urandom);
    bus.rs1   = $urandom;
    bus.rs2   = $urandom;
  endtask
  task automatic wait_done(string name);
    int nb;
    bit seen;
    nb = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++)
      if (bus.done) seen = 1'b1;
      else begin
        if (bus.busy) nb++;
        @(negedge clock);
      end
    check({name, "_done"}, 64'(seen), 64'd1);
    check({name, "_busy"}, 64'(nb), 64'd32);
  endtask
  task automatic after_done(string name, logic [63:0] e);
    @(negedge clock);
    check({name, "_done_fall"}, 64'(bus.done), 64'd0);
    check({name, "_idle"}, 64'(bus.busy), 64'd0);
    check({name, "_hold"}, bus.rd, e);
  endtask
  initial begin
    int base, bad;
    logic [31:0] a, b;
    logic p;
    bus.start = 1'b0;
    bus.poly  = 1'b0;
    bus.rs1   = '0;
    bus.rs2   = '0;
    #1;
    check("reset_rd", bus.rd, 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    v[0] = '{1'b0, 32'd100, 32'd7, 64'h00000002_0000000E};
    v[1] = '{1'b0, 32'hFFFF_FFFF, 32'd1, 64'h00000000_FFFFFFFF};
    v[2] = '{1'b0, 32'h1234, 32'd0, 64'h00001234_FFFFFFFF};
`ifdef CLDIV_EN
    v[3] = '{1'b1, 32'h35, 32'hB, 64'h00000004_00000007};
    v[4] = '{1'b1, 32'h35, 32'h0, 64'h00000035_00000000};
`else
    v[3] = '{1'b1, 32'h35, 32'hB, 64'h00000009_00000004};
    v[4] = '{1'b1, 32'h35, 32'h0, 64'h00000035_FFFFFFFF};
`endif
    v[5] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h00000000_00000001};
    v[6] = '{1'b0, 32'd7, 32'd100, 64'h00000007_00000000};
    v[7] = '{1'b0, 32'h8000_0000, 32'd3, 64'h00000002_2AAAAAAA};
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      launch(v[i].poly, v[i].a, v[i].b, v[i].exp, 1'b1);
      wait_done($sformatf("vec%0d", i));
      after_done($sformatf("vec%0d", i), v[i].exp);
    end
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i == 0) ? 32'd0 : $urandom >> $urandom_range(0, 28);
      p = 1'(i);
      launch(p, a, b, model(p, a, b), 1'b1);
      wait_done($sformatf("rnd%0d", i));
    end
    @(negedge clock);
    // back-to-back: second start lands on the done edge of the first
    launch(1'b0, 32'd1000, 32'd9, int_model(32'd1000, 32'd9), 1'b1);
    wait_done("b2b_a");
    launch(1'b0, 32'd77, 32'd5, int_model(32'd77, 32'd5), 1'b1);
    check("b2b_done_fall", 64'(bus.done), 64'd0);
    wait_done("b2b_b");
    after_done("b2b_b", int_model(32'd77, 32'd5));
    base = done_cnt;
    launch(1'b0, 32'd100, 32'd7, 64'd0, 1'b0);
    repeat (8) @(negedge clock);
    launch(1'b0, 32'h35, 32'hB, 64'h00000009_00000004, 1'b1);
    wait_done("restart");
    after_done("restart", 64'h00000009_00000004);
    check("restart_one_done", 64'(done_cnt - base), 64'd1);
    bad = 0;
    bus.start = 1'b1;
    bus.poly  = 1'b0;
    bus.rs1   = 32'd100;
    bus.rs2   = 32'd7;
    sb.push_back(64'h00000002_0000000E);
    repeat (40) begin
      @(negedge clock);
      if (!bus.busy || bus.done) bad++;
    end
    check("held_start", 64'(bad), 64'd0);
    bus.start = 1'b0;
    wait_done("held_release");
    @(negedge clock);
    base = done_cnt;
    launch(1'b0, 32'hDEAD_BEEF, 32'd3, 64'd0, 1'b0);
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_rst_rd", bus.rd, 64'd0);
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    check("async_rst_done", 64'(bus.done), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("no_done_after_rst", 64'(done_cnt - base), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/simplediv.md
# simplediv

Iterative 32-bit divider producing quotient and remainder at one quotient bit per cycle. It is the inverse-direction companion to the team's multi-cycle (carry-less) multiplier and uses the same start/busy/done handshake and packed 64-bit result. It sits beside the multiplier in the bitmanip execution unit. Integer mode performs unsigned division. An optional carry-less mode performs GF(2) polynomial division.

## Interface
Parameters: none (feature selection via macro, see Configuration).

- clock  in  1  — sole clock; all state updates on rising edge
- reset  in  1  — asynchronous, active-high; clears all state immediately
- start  in  1  — sampled on rising edge; launches a new division
- poly  in  1  — 1 = carry-less (GF(2)) division; sampled with start; ignored without CLDIV_EN
- rs1  in  32  — dividend, captured when start is sampled
- rs2  in  32  — divisor, captured when start is sampled
- rd  out  64  — {remainder[31:0], quotient[31:0]}
- busy  out  1  — iteration in progress
- done  out  1  — one-cycle pulse: rd valid

## Operation
- Registers:
  - q: dividend/quotient shift register, 32 bits.
  - r: partial remainder, 33 bits.
  - d: divisor, 32 bits.
  - m: mode, 1 bit.
  - cnt: iteration counter, 6 bits.
  - done flag.
- Start edge (reset low, start=1): q←rs1, r←0, d←rs2, m←poly (forced 0 without CLDIV_EN), cnt←32, done←0.
- Start has priority over an in-progress operation. The current operation is aborted and no done pulse is produced for it.
- Iteration edge (cnt≠0, start=0): form s = {r[31:0], q[31]}, then shift q left by 1.
- Integer mode (m=0):
  - If s ≥ {1'b0,d}: r←s−d, and the new q LSB is 1.
  - Otherwise: r←s, and the new q LSB is 0.
  - All compares and subtracts are 33-bit unsigned.
- Carry-less mode (m=1):
  - Let t = s[31:0] ^ d.
  - If t < s[31:0] (unsigned): r←{1'b0,t}, and the new q LSB is 1.
  - Otherwise: r←s, and the new q LSB is 0.
  - The test is true exactly when s holds the top set bit of d.
- Each iteration decrements cnt. When cnt goes 1→0, done←1 for exactly one cycle.
- rd = {r[31:0], q}:
  - Valid during the done cycle.
  - Holds its value afterward until the next start or reset.
  - Content while busy is intermediate and is not architecturally meaningful.
- Divide by zero (no special-case logic; results fall out of the algorithm):
  - Integer mode: quotient 0xFFFFFFFF, remainder = rs1.
  - Carry-less mode: quotient 0, remainder = rs1.
- Reset (any time, including mid-operation): q, r, d, m, cnt and done all clear asynchronously. rd=0, busy=0, done=0.

## Timing
- busy = (cnt≠0). It is high for the 32 cycles following the start edge.
- done is high in the cycle after the 32nd iteration edge, i.e. starting 32 edges after the start edge. It drops at the next edge.
- Latency: 33 clock cycles from the start edge to the done edge, inclusive.
- Back-to-back: start may be asserted in the done cycle. The new operation begins at that edge, and done falls.
- start held high re-launches every cycle. busy stays high and done never asserts.
- poly, rs1 and rs2 are don't-care except at start edges.
- Reset values: rd=0, busy=0, done=0.

## Configuration
- CLDIV_EN defined:
  - poly is honoured.
  - Carry-less XOR/compare datapath is compiled in.
- CLDIV_EN undefined:
  - poly is ignored and m is tied to 0.
  - Only integer division exists; the XOR datapath is absent.
  - Results for poly=1 equal integer results.

## Test plan
- Integer: rs1=100, rs2=7, start.
  - Expect busy for 32 cycles, then a single-cycle done with rd=0x00000002_0000000E.
- Integer edge: rs1=0xFFFFFFFF, rs2=1 → rd=0x00000000_FFFFFFFF.
- Divide by zero, integer: rs1=0x1234, rs2=0 → rd=0x00001234_FFFFFFFF.
- Carry-less (CLDIV_EN): poly=1, rs1=0x35, rs2=0xB → rd=0x00000004_00000007.
  - Same stimulus without CLDIV_EN → rd=0x00000009_00000004.
  - Carry-less rs2=0 with rs1=0x35 → rd=0x00000035_00000000.
- Restart and reset:
  - Start 100/7, then re-start with 0x35/0xB at cycle 10. Exactly one done, 32 cycles after the second start, with rd=0x00000009_00000004 (integer mode).
  - Separately, assert reset asynchronously mid-operation. busy, done and rd go to 0 before the next edge, and no done follows.
